regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the team's 3-port register file: two combinational read ports and one synchronous write port.
- Adds configurable width and depth, an optional hardwired zero register, and optional write-to-read bypass.
- Adds a pending-write scoreboard for the future pipelined datapath.
- Adds a hardware clear sequencer that zeroes the array one entry per cycle.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2; AW = $clog2(NREGS).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1 a same-cycle qualified write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  XLEN  write data.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  XLEN  read data, port 1.
- rd2  out  XLEN  read data, port 2.
- sb_set  in  1  mark register sb_addr as pending (instruction issued).
- sb_addr  in  AW  scoreboard set address.
- pend1  out  1  register ra1 has a pending write.
- pend2  out  1  register ra2 has a pending write.
- clr_req  in  1  request a full array clear.
- clr_busy  out  1  clear sequencer active.
- clr_done  out  1  one-cycle pulse on the last clear write.

Behaviour:
Reset
- rst_n low asynchronously clears all registers and all pending bits to 0.
- FSM goes to IDLE, the clear counter goes to 0, clr_busy=0, clr_done=0.
- rd1, rd2, pend1, pend2 therefore read 0 throughout reset.
- Reset asserted mid-clear aborts the sequence immediately; no clr_done pulse.

Write
- Qualified write: we3=1 && clr_busy=0 && !(ZERO_REG && wa3==0).
- A qualified write updates R[wa3] at the rising edge.
- An unqualified write has no effect.

Read
- Combinational. rd = R[ra], with these overrides, highest priority first:
  - (a) clr_busy=1 -> rd=0.
  - (b) ZERO_REG && ra==0 -> rd=0.
  - (c) BYPASS && qualified write && wa3==ra -> rd=wd3.
- BYPASS=0: a read of the address being written returns the old value until after the edge.

Scoreboard
- NREGS pending bits.
- At the rising edge: a qualified write clears pend[wa3]; sb_set=1 sets pend[sb_addr].
- Same address, same edge: set wins, so the bit stays 1 (a new producer has issued).
- sb_set is ignored while clr_busy=1, and for address 0 when ZERO_REG=1.
- pend1=pend[ra1], pend2=pend[ra2], combinational. Bypass does not mask pend.

Clear FSM
- States: IDLE and CLEAR. Counter cnt has width AW.
- IDLE:
  - clr_req=1 -> CLEAR at the next edge, with cnt=0 and all pending bits cleared.
  - Any write in that same cycle is still committed.
- CLEAR:
  - clr_busy=1. Each edge writes R[cnt]=0 and increments cnt.
  - When cnt==NREGS-1, clr_done=1 combinationally in that cycle, and the next edge returns to IDLE.
- Duration: clr_busy is high for exactly NREGS cycles.
- clr_req during CLEAR is ignored (no restart). clr_req held high re-triggers only after IDLE is re-entered.
- cnt wraps naturally at NREGS-1; no extra state.

Latency
- Write-to-read: 1 edge, or 0 with BYPASS=1.
- Set-to-pend: 1 edge.

Test Plan (XLEN=32, NREGS=32, ZERO_REG=1, BYPASS=1 unless stated):
- Async reset mid-cycle, then read ra1=7, ra2=31 -> rd1=0, rd2=0, pend1=0, pend2=0, clr_busy=0 immediately, independent of clk.
- Write R5=A5A5A5A5 and hold ra1=5 in the same cycle -> rd1=A5A5A5A5 before the edge. With BYPASS=0 -> rd1=00000000 before the edge and A5A5A5A5 after it.
- Write R0=FFFFFFFF, then read ra1=0 -> rd1=00000000. sb_set with sb_addr=0, then ra1=0 -> pend1=0.
- sb_set with sb_addr=10 -> pend1=1 (ra1=10). Next edge: write R10=12345678 and sb_set with sb_addr=10 together -> pend1 stays 1. Write R10 alone -> pend1=0, rd1=12345678.
- Fill R1..R31 with nonzero values and set pending on R3, then pulse clr_req:
  - clr_busy high for 32 cycles; clr_done pulses once on the 32nd.
  - Writes of DEADBEEF during CLEAR are dropped; rd=0 throughout.
  - Afterwards all registers read 0 and pend is 0.
- Start a clear, assert rst_n=0 at cycle 10 -> clr_busy=0 at once, no clr_done pulse, all registers 0, FSM IDLE after rst_n is released.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with a pending-write
// scoreboard and a sequencer that clears the array one entry per cycle.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we3,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            pend1,
    output logic            pend2,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   cnt, cnt_nx;
    logic [XLEN-1:0] regs [NREGS];
    logic            pend [NREGS];
    logic            wr_q, sb_q, clr_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        clr_start = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    clr_start = 1'b1;
                    state_nx  = CLEAR;
                    cnt_nx    = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                cnt_nx   = cnt + 1'b1;
                if (cnt == AW'(NREGS - 1)) begin
                    clr_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The clear sequencer owns the array while busy; writes and sets are dropped.
    assign wr_q = we3 && !clr_busy && !(ZERO_REG && wa3 == '0);
    assign sb_q = sb_set && !clr_busy && !(ZERO_REG && sb_addr == '0);

    for (genvar i = 0; i < NREGS; i++) begin : g_ent
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[i] <= '0;
                pend[i] <= 1'b0;
            end else begin
                if (clr_busy && cnt == AW'(i))
                    regs[i] <= '0;
                else if (wr_q && wa3 == AW'(i))
                    regs[i] <= wd3;
                // A set on the same edge as the retiring write means a new producer issued.
                if (clr_start)
                    pend[i] <= 1'b0;
                else if (sb_q && sb_addr == AW'(i))
                    pend[i] <= 1'b1;
                else if (wr_q && wa3 == AW'(i))
                    pend[i] <= 1'b0;
            end
        end
    end

    // Overrides applied lowest priority first so the last assignment wins.
    always_comb begin
        rd1 = regs[ra1];
        if (BYPASS && wr_q && wa3 == ra1) rd1 = wd3;
        if (ZERO_REG && ra1 == '0)        rd1 = '0;
        if (clr_busy)                     rd1 = '0;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (BYPASS && wr_q && wa3 == ra2) rd2 = wd3;
        if (ZERO_REG && ra2 == '0)        rd2 = '0;
        if (clr_busy)                     rd2 = '0;
    end

    assign pend1 = pend[ra1];
    assign pend2 = pend[ra2];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed cases plus random traffic against an array model;
// a second instance with BYPASS=0 shares every input.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we3, sb_set, clr_req;
    logic [AW-1:0]   wa3, ra1, ra2, sb_addr;
    logic [XLEN-1:0] wd3;
    logic [XLEN-1:0] rd1, rd2, rd1_nb, rd2_nb;
    logic            pend1, pend2, clr_busy, clr_done;
    logic            pend1_nb, pend2_nb, busy_nb, done_nb;

    int n_chk = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_pend [NREGS];
    int              m_left;
    int              busy_seen, done_seen, done_at;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1), .pend2(pend2),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1_nb), .pend2(pend2_nb),
        .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the clear is tracked as "cycles remaining".
    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = 0;
    endtask

    function automatic bit m_wq();
        return we3 && m_left == 0 && wa3 != 0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [AW-1:0] ra, input bit byp);
        if (m_left != 0 || ra == 0) return '0;
        if (byp && m_wq() && wa3 == ra) return wd3;
        return m_reg[ra];
    endfunction

    task automatic m_edge();
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (m_left != 0) begin
            m_reg[NREGS - m_left] = '0;
            m_left--;
            return;
        end
        if (m_wq()) begin
            m_reg[wa3]  = wd3;
            m_pend[wa3] = 1'b0;
        end
        if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
        if (clr_req) begin
            m_left = NREGS;
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("rd1",     rd1,      m_rd(ra1, 1'b1));
        chk("rd2",     rd2,      m_rd(ra2, 1'b1));
        chk("rd1_nb",  rd1_nb,   m_rd(ra1, 1'b0));
        chk("rd2_nb",  rd2_nb,   m_rd(ra2, 1'b0));
        chk("pend1",   pend1,    m_pend[ra1]);
        chk("pend2",   pend2,    m_pend[ra2]);
        chk("pend1_nb", pend1_nb, m_pend[ra1]);
        chk("busy",    clr_busy, m_left != 0);
        chk("done",    clr_done, m_left == 1);
        chk("busy_nb", busy_nb,  m_left != 0);
        if (clr_busy) busy_seen++;
        if (clr_done) begin
            done_seen++;
            done_at = busy_seen;
        end
    endtask

    // Inputs are driven at posedge+1; outputs checked at posedge+3.
    task automatic cyc();
        #2 check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        we3 = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; idle();
        wa3 = '0; wd3 = '0; sb_addr = '0; ra1 = 5'd7; ra2 = 5'd31;
        busy_seen = 0; done_seen = 0; done_at = 0;

        // asynchronous reset between edges
        #3 rst_n = 1'b0; m_reset();
        #1;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_pend1", pend1, 1'b0);
        chk("rst_pend2", pend2, 1'b0);
        chk("rst_busy", clr_busy, 1'b0);
        @(posedge clk); #1;
        chk("rst_hold_rd1", rd1, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // bypass vs no bypass
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hA5A5A5A5; ra1 = 5'd5;
        #1;
        chk("byp_pre", rd1, 32'hA5A5A5A5);
        chk("nobyp_pre", rd1_nb, 32'h0);
        cyc();
        idle();
        #1;
        chk("nobyp_post", rd1_nb, 32'hA5A5A5A5);
        chk("byp_post", rd1, 32'hA5A5A5A5);

        // hardwired zero register
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF; ra1 = 5'd0;
        cyc();
        idle();
        #1 chk("zero_rd", rd1, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd0;
        cyc();
        idle();
        #1 chk("zero_pend", pend1, 1'b0);

        // scoreboard set/clear and set-wins
        sb_set = 1'b1; sb_addr = 5'd10; ra1 = 5'd10;
        cyc();
        idle();
        #1 chk("sb_set", pend1, 1'b1);
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h12345678; sb_set = 1'b1; sb_addr = 5'd10;
        cyc();
        idle();
        #1 chk("sb_setwins", pend1, 1'b1);
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h12345678;
        cyc();
        idle();
        #1;
        chk("sb_clr", pend1, 1'b0);
        chk("sb_rd", rd1, 32'h12345678);

        // full clear with writes attempted throughout
        for (int i = 1; i < NREGS; i++) begin
            we3 = 1'b1; wa3 = AW'(i); wd3 = $urandom | 32'h1;
            cyc();
        end
        idle();
        sb_set = 1'b1; sb_addr = 5'd3;
        cyc();
        idle();
        ra1 = 5'd3;
        #1 chk("pre_clr_pend", pend1, 1'b1);
        clr_req = 1'b1; busy_seen = 0; done_seen = 0; done_at = 0;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            we3 = 1'b1; wa3 = AW'($urandom); wd3 = 32'hDEADBEEF;
            ra1 = AW'($urandom); ra2 = AW'($urandom); sb_set = 1'b1; sb_addr = AW'($urandom);
            cyc();
        end
        idle();
        chk("clr_len", busy_seen, 32);
        chk("clr_done_n", done_seen, 1);
        chk("clr_done_at", done_at, 32);
        for (int i = 0; i < NREGS; i++) begin
            ra1 = AW'(i); ra2 = AW'(NREGS - 1 - i);
            #1;
            chk("clr_rd", rd1, 32'h0);
            chk("clr_pend", pend1, 1'b0);
            cyc();
        end

        // reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            we3 = 1'b1; wa3 = AW'(20 + i); wd3 = $urandom | 32'h1;
            cyc();
        end
        idle();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0; busy_seen = 0; done_seen = 0;
        repeat (10) cyc();
        #1 rst_n = 1'b0; m_reset();
        #1;
        chk("rstclr_busy", clr_busy, 1'b0);
        chk("rstclr_done", clr_done, 1'b0);
        cyc();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstclr_nodone", done_seen, 0);
        for (int i = 0; i < NREGS; i++) begin
            ra1 = AW'(i); ra2 = AW'(i);
            #1 chk("rstclr_rd", rd1, 32'h0);
            cyc();
        end
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h00001234;
        cyc();
        idle();
        ra1 = 5'd9;
        #1 chk("post_rst_wr", rd1, 32'h00001234);

        // random traffic
        repeat (3000) begin
            we3     = $urandom_range(0, 9) < 7;
            wa3     = AW'($urandom);
            wd3     = $urandom;
            ra1     = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom);
            ra2     = ($urandom_range(0, 3) == 0) ? sb_addr : AW'($urandom);
            sb_set  = $urandom_range(0, 1) == 1;
            sb_addr = AW'($urandom);
            clr_req = $urandom_range(0, 99) == 0;
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
